cpu_fetch_decode: RTL

- Instruction fetch/decode stage of cpu_v1, directly upstream of the ALU.
- Holds the program counter and reads 32-bit instructions from an external synchronous-read instruction ROM.
- Decodes each instruction into ALU op, register addresses, immediate and control strobes, presented to the register file/ALU with a valid/ready handshake.
- Supports sequential execution, jumps and halt.

---
 rtl/cpu_fetch_decode.sv | 89 ++++++++
 1 files changed

// File: rtl/cpu_fetch_decode.sv
// cpu_fetch_decode: PC, synchronous-ROM fetch, decode and valid/ready issue to the ALU stage.
// Optional COND_BRANCH_EN: a JUMP with bit 29 set is taken only when alu_zero is high at accept.
module cpu_fetch_decode #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [31:0]       rom_data,
    input  logic              alu_zero,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [2:0]        alu_op,
    output logic [4:0]        rd_addr,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    output logic [31:0]       imm,
    output logic              a_sel_imm,
    output logic              wr_en,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE, S_HALT} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, jmp_tgt;
    logic [1:0] cls;
    logic is_jump, is_halt, jmp_cond, take;
    assign cls = rom_data[31:30];
`ifdef COND_BRANCH_EN
    assign take = is_jump && (!jmp_cond || alu_zero);
`else
    logic unused_cond;
    assign unused_cond = alu_zero ^ jmp_cond;
    assign take = is_jump;
`endif
    assign rom_addr = pc;
    assign rom_en = state == S_FETCH && !rst;
    assign dec_valid = state == S_ISSUE;
    assign halted = state == S_HALT;
    always_comb begin
        state_nxt = state;
        pc_nxt = pc;
        case (state)
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_ISSUE;
            S_ISSUE: if (dec_ready) begin
                state_nxt = is_halt ? S_HALT : S_FETCH;
                pc_nxt = is_halt ? pc : take ? jmp_tgt : pc + ADDR_W'(1);
            end
            default: state_nxt = S_HALT;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_FETCH;
            pc <= '0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
        end
    // Decoded fields are captured while the ROM output is valid and then held through issue.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            alu_op <= '0;
            rd_addr <= '0;
            rs1_addr <= '0;
            rs2_addr <= '0;
            imm <= '0;
            a_sel_imm <= 1'b0;
            wr_en <= 1'b0;
            is_jump <= 1'b0;
            is_halt <= 1'b0;
            jmp_cond <= 1'b0;
            jmp_tgt <= '0;
        end else if (state == S_WAIT) begin
            alu_op <= cls == 2'b00 ? rom_data[29:27] : 3'd0;
            rd_addr <= cls[1] ? 5'd0 : rom_data[26:22];
            rs1_addr <= cls == 2'b00 ? rom_data[21:17] : 5'd0;
            rs2_addr <= cls == 2'b00 ? rom_data[16:12] : 5'd0;
            imm <= cls == 2'b01 ? {{10{rom_data[21]}}, rom_data[21:0]} : 32'd0;
            a_sel_imm <= cls == 2'b01;
            wr_en <= !cls[1];
            is_jump <= cls == 2'b10;
            is_halt <= cls == 2'b11;
            jmp_cond <= rom_data[29];
            jmp_tgt <= rom_data[ADDR_W-1:0];
        end
endmodule
